// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 1024x768 @ 70 Hz VGA raster generator.
// Contents: VESA timing constants (75 MHz pixel clock, 1328x806 total),
// pixel width and RGB111 colour constants, and the coordinate and flag types
// used by the counter and the alignment pipeline.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int DW = 3;   // RGB111

  localparam int H_VISIBLE = 1024;
  localparam int H_FRONT   = 24;
  localparam int H_SYNC    = 136;
  localparam int H_BACK    = 144;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 1328

  localparam int V_VISIBLE = 768;
  localparam int V_FRONT   = 3;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 29;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 806

  // Largest count is 1327, so 12 bits never overflow.
  localparam int CW = 12;

  typedef logic [CW-1:0] coord_t;
  typedef logic [DW-1:0] pixel_t;

  localparam pixel_t RED   = 3'b100;
  localparam pixel_t GREEN = 3'b010;
  localparam pixel_t BLUE  = 3'b001;

  // Per-position decode, travels down the alignment pipeline as one unit.
  typedef struct packed {
    logic visible;
    logic hs;
    logic vs;
  } raster_flags_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_1024x768_if.sv
// -----------------------------------------------------------------------------
// vga_timing_1024x768_if
// Bundles the frame-buffer read side and the VGA pin side of the raster
// generator.
//   posX/posY  : read address towards the frame-buffer RAM (zero latency)
//   pixelIn    : RAM read data, valid one cycle after posX/posY
//   pixelOut   : gated pixel to the VGA pins
//   Hsync_n    : horizontal sync, active low
//   Vsync_n    : vertical sync, active low
// master = the timing generator, slave = RAM/pin side.
// -----------------------------------------------------------------------------
interface vga_timing_1024x768_if;
  import vga_pkg::*;

  pixel_t pixelIn;
  pixel_t pixelOut;
  logic   Hsync_n;
  logic   Vsync_n;
  coord_t posX;
  coord_t posY;

  modport master (
    input  pixelIn,
    output pixelOut, Hsync_n, Vsync_n, posX, posY
  );

  modport slave (
    output pixelIn,
    input  pixelOut, Hsync_n, Vsync_n, posX, posY
  );

endinterface

// File: rtl/vga_timing_1024x768_sync_counter.sv
// -----------------------------------------------------------------------------
// vga_sync_counter
// Horizontal/vertical raster counters plus the stage-0 decode of the current
// position into visible / hsync / vsync flags.
//   clk   : pixel clock
//   rst   : synchronous, active-high reset (counters to 0,0)
//   hcnt  : 0 .. H_TOTAL-1, advances every clock
//   vcnt  : 0 .. V_TOTAL-1, advances when hcnt wraps
//   flags : combinational decode of (hcnt, vcnt)
// -----------------------------------------------------------------------------
module vga_sync_counter #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                  clk,
  input  logic                  rst,
  output vga_pkg::coord_t       hcnt,
  output vga_pkg::coord_t       vcnt,
  output vga_pkg::raster_flags_t flags
);
  import vga_pkg::*;

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_ACTIVE = coord_t'(H_VISIBLE);
  localparam coord_t V_ACTIVE = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  // NOTE: non-blocking (<=) so both counters update from pre-edge values;
  // blocking here would make vcnt depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + coord_t'(1);
    end else begin
      hcnt <= hcnt + coord_t'(1);
    end
  end

  // NOTE: default first so every path assigns flags and no latch is inferred.
  always_comb begin
    flags         = '0;
    flags.visible = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
    flags.hs      = in_window(hcnt, HS_START, HS_END);
    flags.vs      = in_window(vcnt, VS_START, VS_END);
  end

endmodule

// File: rtl/vga_timing_1024x768.sv
// -----------------------------------------------------------------------------
// vga_timing_1024x768
// Raster timing generator and pixel gate for a 1024x768 @ 70 Hz display.
// The counters address the frame-buffer RAM directly; the decoded flags are
// delayed two clocks so they line up with the RAM's one-cycle read data, and
// the pixel is forced to 0 outside the visible area.
//   clk : 75 MHz pixel clock
//   rst : synchronous, active-high reset
//   vga : master side of vga_timing_1024x768_if (posX/posY/pixelIn/
//         pixelOut/Hsync_n/Vsync_n)
// Outputs in cycle t+2 describe the position presented in cycle t.
// -----------------------------------------------------------------------------
module vga_timing_1024x768 #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input logic                   clk,
  input logic                   rst,
  vga_timing_1024x768_if.master vga
);
  import vga_pkg::*;

  coord_t        hcnt;
  coord_t        vcnt;
  raster_flags_t flags_s0;
  raster_flags_t flags_d1;

  vga_sync_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .flags (flags_s0)
  );

  // Address goes straight from the counter registers so the RAM sees it
  // with no added latency.
  assign vga.posX = hcnt;
  assign vga.posY = vcnt;

  // Stage 1 holds the decode while the RAM reads; stage 2 meets the returned
  // pixel and drives the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_d1     <= '0;
      vga.pixelOut <= '0;
      vga.Hsync_n  <= 1'b1;
      vga.Vsync_n  <= 1'b1;
    end else begin
      flags_d1     <= flags_s0;
      vga.pixelOut <= flags_d1.visible ? vga.pixelIn : '0;
      vga.Hsync_n  <= ~flags_d1.hs;
      vga.Vsync_n  <= ~flags_d1.vs;
    end
  end

endmodule

// File: tb/tb_vga_timing_1024x768.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_1024x768
// Two instances share one clock: dut_m uses the full 1024x768 geometry for the
// horizontal, pixel-gate, alignment and mid-frame reset scenarios; dut_s uses a
// scaled-down geometry so whole frames (vertical sync, blank lines) and many
// random resets fit in a short run. A position/time model checks every output
// of both instances on every cycle.
// -----------------------------------------------------------------------------
module tb_vga_timing_1024x768;
  import vga_pkg::*;

  typedef struct {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
  } geom_t;

  geom_t g_main  = '{hv:1024, hf:24, hs:136, hb:144, vv:768, vf:3, vs:6, vb:29};
  geom_t g_small = '{hv:16,   hf:2,  hs:4,   hb:3,   vv:12,  vf:2, vs:3, vb:2};

  logic clk = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  // Cycles since the last reset edge; -1 until the first reset is seen.
  int k_m = -1;
  int k_s = -1;
  pixel_t prev_pix_m;
  pixel_t prev_pix_s;

  int     mode_m = 0;   // 0: constant RED|BLUE, 1: RAM returning posX[2:0]
  coord_t ram_addr;

  vga_timing_1024x768_if vga_m ();
  vga_timing_1024x768_if vga_s ();

  vga_timing_1024x768 dut_m (
    .clk (clk),
    .rst (rst_m),
    .vga (vga_m)
  );

  vga_timing_1024x768 #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (3), .V_BACK (2)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .vga (vga_s)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected outputs from elapsed time alone: the position at time k is
  // k mod H_TOTAL / (k div H_TOTAL) mod V_TOTAL, and outputs describe the
  // position two clocks earlier.
  task automatic compare(string tag, geom_t g, int k, pixel_t pin,
                         coord_t px, coord_t py, pixel_t po,
                         logic hs_n, logic vs_n);
    int     ht, vt, x, y;
    pixel_t e_pix;
    logic   e_hs, e_vs;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    e_pix = '0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    if (k >= 2) begin
      x = (k - 2) % ht;
      y = ((k - 2) / ht) % vt;
      if (x < g.hv && y < g.vv) e_pix = pin;
      e_hs = !(x >= g.hv + g.hf && x < g.hv + g.hf + g.hs);
      e_vs = !(y >= g.vv + g.vf && y < g.vv + g.vf + g.vs);
    end
    check($sformatf("%s posX k=%0d", tag, k), 32'(px), k % ht);
    check($sformatf("%s posY k=%0d", tag, k), 32'(py), (k / ht) % vt);
    check($sformatf("%s pixelOut k=%0d", tag, k), 32'(po), 32'(e_pix));
    check($sformatf("%s Hsync_n k=%0d", tag, k), 32'(hs_n), 32'(e_hs));
    check($sformatf("%s Vsync_n k=%0d", tag, k), 32'(vs_n), 32'(e_vs));
  endtask

  // Elapsed-time bookkeeping, sampled on the active edge.
  always @(posedge clk) begin
    if (rst_m) k_m <= 0;
    else if (k_m >= 0) k_m <= k_m + 1;
    if (rst_s) k_s <= 0;
    else if (k_s >= 0) k_s <= k_s + 1;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (k_m >= 0)
      compare("m", g_main, k_m, prev_pix_m, vga_m.posX, vga_m.posY,
              vga_m.pixelOut, vga_m.Hsync_n, vga_m.Vsync_n);
    if (k_s >= 0)
      compare("s", g_small, k_s, prev_pix_s, vga_s.posX, vga_s.posY,
              vga_s.pixelOut, vga_s.Hsync_n, vga_s.Vsync_n);
    prev_pix_m <= vga_m.pixelIn;
    prev_pix_s <= vga_s.pixelIn;
    ram_addr   <= vga_m.posX;
  end

  // Frame-buffer side: one-cycle-latency RAM (address captured in cycle t,
  // data presented in cycle t+1) or a constant; random data for dut_s.
  always @(posedge clk) begin
    #1;
    vga_m.pixelIn = (mode_m == 1) ? ram_addr[2:0] : (RED | BLUE);
    vga_s.pixelIn = 3'($urandom_range(7));
  end

  task automatic wait_pos(int x, int y, int budget, string name);
    int n = 0;
    while (!(vga_m.posX == coord_t'(x) && (y < 0 || vga_m.posY == coord_t'(y)))
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(vga_m.posX == coord_t'(x)), 32'd1);
  endtask

  // Entered just after the last reset edge (cycle 0 of a fresh frame).
  task automatic check_restart(string tag);
    @(negedge clk);
    check({tag, " c0 posX"}, 32'(vga_m.posX), 32'd0);
    check({tag, " c0 posY"}, 32'(vga_m.posY), 32'd0);
    check({tag, " c0 Hsync_n"}, 32'(vga_m.Hsync_n), 32'd1);
    check({tag, " c0 Vsync_n"}, 32'(vga_m.Vsync_n), 32'd1);
    check({tag, " c0 pixelOut"}, 32'(vga_m.pixelOut), 32'd0);
    repeat (1327) @(posedge clk);
    @(negedge clk);
    check({tag, " c1327 posX"}, 32'(vga_m.posX), 32'd1327);
    check({tag, " c1327 posY"}, 32'(vga_m.posY), 32'd0);
    @(negedge clk);
    check({tag, " c1328 posX"}, 32'(vga_m.posX), 32'd0);
    check({tag, " c1328 posY"}, 32'(vga_m.posY), 32'd1);
  endtask

  task automatic run_main();
    int d, w, c;
    mode_m = 0;
    rst_m  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_m = 1'b0;
    check_restart("first");

    // Hsync: low 2 clocks after posX=1048 is first presented, for 136 clocks.
    wait_pos(1048, -1, 2000, "wait posX=1048");
    d = 0;
    while (vga_m.Hsync_n !== 1'b0 && d < 10) begin @(negedge clk); d++; end
    check("hsync delay", 32'(d), 32'd2);
    w = 0;
    while (vga_m.Hsync_n === 1'b0 && w < 2000) begin @(negedge clk); w++; end
    check("hsync width", 32'(w), 32'd136);

    // Pixel gate: 1024 clocks of RED|BLUE starting 2 clocks after posX=0.
    wait_pos(0, -1, 2000, "wait posX=0");
    repeat (2) @(negedge clk);
    c = 0;
    while (vga_m.pixelOut === 3'b101 && c < 2000) begin @(negedge clk); c++; end
    check("gate width", 32'(c), 32'd1024);
    check("gate after", 32'(vga_m.pixelOut), 32'd0);

    // Mid-frame reset: rst high during the cycle presenting (500,3).
    wait_pos(499, 3, 3000, "wait (499,3)");
    @(posedge clk);
    #1 rst_m = 1'b1;
    @(negedge clk);
    check("mid pre posX", 32'(vga_m.posX), 32'd500);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held posX", 32'(vga_m.posX), 32'd0);
      check("held posY", 32'(vga_m.posY), 32'd0);
      check("held pixelOut", 32'(vga_m.pixelOut), 32'd0);
      check("held Hsync_n", 32'(vga_m.Hsync_n), 32'd1);
      check("held Vsync_n", 32'(vga_m.Vsync_n), 32'd1);
    end
    @(posedge clk);
    #1 rst_m = 1'b0;
    check_restart("restart");

    // Alignment with the RAM model across full visible lines.
    mode_m = 1;
    repeat (1400) @(negedge clk);
    wait_pos(7, -1, 1400, "wait posX=7");
    repeat (2) @(negedge clk);
    check("ram align x=7", 32'(vga_m.pixelOut), 32'd7);
    repeat (1400) @(negedge clk);
  endtask

  task automatic run_small();
    int   falls[$];
    int   run_len, low_cnt;
    logic prev_vs;
    rst_s = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_s = 1'b0;

    // Three undisturbed frames (25x19 = 475 clocks each).
    prev_vs = 1'b1;
    run_len = -1;
    low_cnt = 0;
    for (int i = 0; i < 1425; i++) begin
      @(negedge clk);
      if (prev_vs === 1'b1 && vga_s.Vsync_n === 1'b0) falls.push_back(i);
      if (vga_s.Vsync_n === 1'b0) low_cnt++;
      else if (prev_vs === 1'b0 && run_len < 0) run_len = low_cnt;
      prev_vs = vga_s.Vsync_n;
    end
    check("small vsync falls seen", 32'(falls.size() >= 2), 32'd1);
    if (falls.size() >= 2) begin
      check("small vsync first fall", 32'(falls[0]), 32'd352);
      check("small vsync period", 32'(falls[1] - falls[0]), 32'd475);
    end
    check("small vsync width", 32'(run_len), 32'd75);

    // Random resets at arbitrary points in the frame.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(600, 40)) @(posedge clk);
      #1 rst_s = 1'b1;
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1 rst_s = 1'b0;
    end
    repeat (600) @(posedge clk);
  endtask

  initial begin
    fork
      run_main();
      run_small();
    join
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_1024x768.md
Name: vga_timing_1024x768

Overview:
- Raster timing generator and pixel gate for a 1024x768 VGA display.
- Runs on the 75 MHz pixel clock (VESA 1024x768 @ 70 Hz, 1328x806 total).
- Drives posX/posY as the read address source for the frame-buffer dual-port RAM, which has a one-cycle read latency.
- Re-aligns the returned pixel with the delayed sync pulses, blanks outside the visible area and drives the VGA pins.

Parameters:
- DW, 3, pixel width (RGB 111).
- H_VISIBLE, 1024, active pixels per line.
- H_FRONT, 24, horizontal front porch (clocks).
- H_SYNC, 136, horizontal sync width.
- H_BACK, 144, horizontal back porch.
- V_VISIBLE, 768, active lines.
- V_FRONT, 3, vertical front porch (lines).
- V_SYNC, 6, vertical sync width.
- V_BACK, 29, vertical back porch.

Ports:
- clk  in  1  75 MHz pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pixelIn  in  DW  pixel from frame-buffer RAM; valid one cycle after posX/posY are presented.
- pixelOut  out  DW  pixel to VGA pins; forced 0 when blanked.
- Hsync_n  out  1  horizontal sync, active low.
- Vsync_n  out  1  vertical sync, active low.
- posX  out  12  current horizontal counter, 0..H_TOTAL-1.
- posY  out  12  current vertical counter, 0..V_TOTAL-1.

Behaviour:
- H_TOTAL = sum of the four H parameters = 1328. V_TOTAL = 806.
- Counters:
  - hcnt increments every clock and wraps from H_TOTAL-1 to 0.
  - vcnt increments when hcnt wraps, and wraps from V_TOTAL-1 to 0 at that same edge.
  - posX = hcnt and posY = vcnt, driven directly from the counter registers (zero latency).
- Stage-0 decode, from the counters:
  - visible = hcnt < H_VISIBLE && vcnt < V_VISIBLE.
  - hs = hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 1048..1183.
  - vs = vcnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 771..776.
- Pipeline (fixed 2-cycle latency):
  - Stage 1 registers visible, hs and vs.
  - Stage 2 registers pixelOut = visible_d1 ? pixelIn : 0, Hsync_n = ~hs_d1 and Vsync_n = ~vs_d1.
  - Outputs during cycle t+2 therefore describe the position presented on posX/posY in cycle t.
  - pixelIn is sampled at the edge ending cycle t+1, matching the RAM's one-cycle read latency.
- Reset (rst=1 at a rising edge) forces all of the following on the next cycle:
  - hcnt = vcnt = 0.
  - All pipeline flags cleared.
  - pixelOut = 0, Hsync_n = 1, Vsync_n = 1.
- Reset asserted mid-frame aborts the frame immediately; the first frame after release starts at (0,0).
- While rst is held, outputs stay at their reset values.
- Counter widths: 12 bits. No arithmetic overflow is possible because the maximum value is 1327.
- Frame period: H_TOTAL*V_TOTAL = 1,070,368 clocks (≈70.07 Hz at 75 MHz).
- Sync polarity is negative for both sync outputs and is not parameterised.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (visible, porch and sync widths; H_TOTAL/V_TOTAL);
  - the DW pixel width;
  - the RGB111 colour constants RED=100, GREEN=010 and BLUE=001.
- One natural sub-module, vga_sync_counter: the hcnt/vcnt counters plus the visible/hs/vs decode.
- The top of this block adds the 2-stage alignment pipeline and the pixel gate.
- The frame-buffer RAM and the 75 MHz PLL are separate blocks and are not part of this design.

Test Plan:
- Reset then release:
  - Cycle 0: posX=0, posY=0, Hsync_n=1, Vsync_n=1, pixelOut=000.
  - After 1327 clocks, posX=1327; next clock posX=0 and posY=1.
- Hsync timing: Hsync_n is low for exactly 136 clocks per line, starting 2 clocks after posX=1048 is first presented. It stays high otherwise, including throughout vertical blanking lines.
- Vsync timing:
  - Vsync_n is low for exactly 6*1328 = 7968 clocks.
  - It starts 2 clocks after (posX=0, posY=771).
  - Consecutive falling edges are 1,070,368 clocks apart.
- Pixel gate with pixelIn held at 101:
  - pixelOut=101 from 2 clocks after (0,0) until 2 clocks after posX=1024 on the same line, then 000.
  - All lines with posY≥768 give 000.
- Alignment with a behavioural 1-cycle-latency RAM model returning posX[2:0]: pixelOut in cycle t+2 equals posX[2:0] presented in cycle t across a full visible line.
- Mid-frame reset: assert rst at (posX=500, posY=400).
  - Next cycle posX=posY=0 and the outputs are at reset values.
  - After release, the counting sequence restarts identically to the first test.
